block_raster_writer: RTL and testbench

BLOCK_RASTER_WRITER -- requirements
Module: block_raster_writer

---
 rtl/vw_pkg.sv | 21 ++
 rtl/block_addr_gen.sv | 82 ++++++++
 rtl/block_raster_writer.sv | 148 ++++++++++++++
 tb/tb_block_raster_writer.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/vw_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// vw_pkg : shared FSM encoding and size limits for block_raster_writer
// Rev 1.0
// ------------------------------------------------------------------
package vw_pkg;

  localparam int Max_Img_Size   = 720;
  localparam int Max_Block_Size = 127;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_DIV  = 3'd1,
    ST_MUL  = 3'd2,
    ST_RUN  = 3'd3,
    ST_DONE = 3'd4,
    ST_ERR  = 3'd5
  } state_t;

endpackage
`default_nettype wire

// File: rtl/block_addr_gen.sv
`default_nettype none
// ------------------------------------------------------------------
// block_addr_gen : walks block-ordered beats, yields raster addresses
// Rev 1.0
// ------------------------------------------------------------------
module block_addr_gen
  import vw_pkg::*;
#(
  parameter int ADDR_W = 20,
  parameter int CNT_W  = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              init,
  input  logic              step,
  input  logic [CNT_W-1:0]  m,
  input  logic [CNT_W-1:0]  bpr,
  input  logic [9:0]        np,
  input  logic [ADDR_W-1:0] stride,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);

  localparam logic [CNT_W-1:0] c_one = CNT_W'(1);

  logic [CNT_W-1:0]  r_col, r_row, r_bcol, r_brow;
  logic [ADDR_W-1:0] r_blk_origin, r_rowblk_origin, r_row_base;
  logic              w_col_end, w_row_end, w_bcol_end, w_brow_end;

  assign w_col_end  = (r_col  == m - c_one);
  assign w_row_end  = (r_row  == m - c_one);
  assign w_bcol_end = (r_bcol == bpr - c_one);
  assign w_brow_end = (r_brow == bpr - c_one);

  assign addr = r_blk_origin + r_row_base + ADDR_W'(r_col);
  assign last = w_col_end && w_row_end && w_bcol_end && w_brow_end;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_col           <= '0;
      r_row           <= '0;
      r_bcol          <= '0;
      r_brow          <= '0;
      r_blk_origin    <= '0;
      r_rowblk_origin <= '0;
      r_row_base      <= '0;
    end else if (init) begin
      r_col           <= '0;
      r_row           <= '0;
      r_bcol          <= '0;
      r_brow          <= '0;
      r_blk_origin    <= '0;
      r_rowblk_origin <= '0;
      r_row_base      <= '0;
    end else if (step) begin
      if (!w_col_end) begin
        r_col <= r_col + c_one;
      end else begin
        r_col <= '0;
        if (!w_row_end) begin
          r_row      <= r_row + c_one;
          r_row_base <= r_row_base + ADDR_W'(np);
        end else begin
          r_row      <= '0;
          r_row_base <= '0;
          // Last block of a block-row jumps down one full block-row.
          if (!w_bcol_end) begin
            r_bcol       <= r_bcol + c_one;
            r_blk_origin <= r_blk_origin + ADDR_W'(m);
          end else begin
            r_bcol          <= '0;
            r_brow          <= r_brow + c_one;
            r_blk_origin    <= r_rowblk_origin + stride;
            r_rowblk_origin <= r_rowblk_origin + stride;
          end
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/block_raster_writer.sv
`default_nettype none
// ------------------------------------------------------------------
// block_raster_writer : reorders block-ordered pixel beats into raster writes
// Rev 1.0
// ------------------------------------------------------------------
module block_raster_writer
  import vw_pkg::*;
#(
  parameter int Data_Depth      = 8,
  parameter int Channels        = 1,
  parameter int Amba_Addr_Depth = 20,
  parameter int Block_Depth     = 7,
  parameter int Max_Img_Size    = vw_pkg::Max_Img_Size
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           cfg_start,
  input  logic [9:0]                     cfg_Np,
  input  logic [Block_Depth-1:0]         cfg_M,
  input  logic                           cfg_bypass,
  input  logic                           in_valid,
  input  logic [Channels*Data_Depth-1:0] in_data,
  output logic                           in_ready,
  output logic                           wr_en,
  output logic [Amba_Addr_Depth-1:0]     wr_addr,
  output logic [Channels*Data_Depth-1:0] wr_data,
  input  logic                           wr_ready,
  output logic                           busy,
  output logic                           frame_done,
  output logic                           cfg_err
);

  localparam int CW = (Block_Depth > 10) ? Block_Depth : 10;
  localparam logic [CW-1:0]          c_one_cw = CW'(1);
  localparam logic [Block_Depth-1:0] c_one_m  = Block_Depth'(1);

  state_t                     r_state, w_next;
  logic [9:0]                 r_np;
  logic [Block_Depth-1:0]     r_m, r_mcnt;
  logic                       r_bypass, r_all;
  logic [CW-1:0]              r_rem, r_bpr;
  logic [Amba_Addr_Depth-1:0] r_stride, w_addr;
  logic [CW-1:0]              w_m_ext, w_m_eff, w_bpr_eff;
  logic                       w_cfg_bad, w_accept, w_wr_done, w_init, w_last;

  assign w_m_ext   = CW'(r_m);
  // Bypass is a single Np x Np block, which the block walker emits in raster order.
  assign w_m_eff   = r_bypass ? CW'(r_np) : w_m_ext;
  assign w_bpr_eff = r_bypass ? c_one_cw : r_bpr;

  assign w_cfg_bad = (cfg_M == '0) || (cfg_Np == '0) ||
                     (int'(cfg_Np) > Max_Img_Size) || (int'(cfg_M) > Max_Block_Size);
  assign in_ready   = (r_state == ST_RUN) && !r_all && (!wr_en || wr_ready);
  assign w_accept   = in_valid && in_ready;
  assign w_wr_done  = wr_en && wr_ready;
  assign w_init     = cfg_start && ((r_state == ST_IDLE) || (r_state == ST_ERR));
  assign busy       = (r_state == ST_DIV) || (r_state == ST_MUL) ||
                      (r_state == ST_RUN) || (r_state == ST_DONE);
  assign frame_done = (r_state == ST_DONE);

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE, ST_ERR: if (cfg_start)
                         w_next = w_cfg_bad ? ST_ERR : (cfg_bypass ? ST_RUN : ST_DIV);
      ST_DIV:          if (r_rem < w_m_ext) w_next = (r_rem == '0) ? ST_MUL : ST_ERR;
      ST_MUL:          if (r_mcnt == r_m - c_one_m) w_next = ST_RUN;
      ST_RUN:          if (r_all && w_wr_done) w_next = ST_DONE;
      ST_DONE:         w_next = ST_IDLE;
      default:         w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= ST_IDLE;
      r_np     <= '0;
      r_m      <= '0;
      r_bypass <= 1'b0;
      r_rem    <= '0;
      r_bpr    <= '0;
      r_mcnt   <= '0;
      r_stride <= '0;
      r_all    <= 1'b0;
      cfg_err  <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        ST_IDLE, ST_ERR: if (cfg_start) begin
          r_np     <= cfg_Np;
          r_m      <= cfg_M;
          r_bypass <= cfg_bypass;
          r_rem    <= CW'(cfg_Np);
          r_bpr    <= '0;
          r_mcnt   <= '0;
          r_stride <= '0;
          r_all    <= 1'b0;
          cfg_err  <= w_cfg_bad;
        end
        // Blocks-per-row by repeated subtraction; a remainder means M does not tile Np.
        ST_DIV: if (r_rem >= w_m_ext) begin
          r_rem <= r_rem - w_m_ext;
          r_bpr <= r_bpr + c_one_cw;
        end else if (r_rem != '0) begin
          cfg_err <= 1'b1;
        end
        ST_MUL: begin
          r_stride <= r_stride + Amba_Addr_Depth'(r_np);
          r_mcnt   <= r_mcnt + c_one_m;
        end
        ST_RUN: if (w_accept && w_last) r_all <= 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else if (w_accept) begin
      wr_en   <= 1'b1;
      wr_addr <= w_addr;
      wr_data <= in_data;
    end else if (wr_ready) begin
      wr_en   <= 1'b0;
    end
  end

  block_addr_gen #(
    .ADDR_W (Amba_Addr_Depth),
    .CNT_W  (CW)
  ) u_addr_gen (
    .clk    (clk),
    .rst    (rst),
    .init   (w_init),
    .step   (w_accept),
    .m      (w_m_eff),
    .bpr    (w_bpr_eff),
    .np     (r_np),
    .stride (r_stride),
    .addr   (w_addr),
    .last   (w_last)
  );

endmodule
`default_nettype wire

// File: tb/tb_block_raster_writer.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_block_raster_writer : scoreboard bench for block_raster_writer
// Rev 1.0
// ------------------------------------------------------------------
module tb_block_raster_writer;

  localparam int DW = 24;
  localparam int AW = 20;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          cfg_start = 1'b0;
  logic [9:0]    cfg_Np = '0;
  logic [6:0]    cfg_M = '0;
  logic          cfg_bypass = 1'b0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_ready;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          wr_ready = 1'b1;
  logic          busy, frame_done, cfg_err;

  block_raster_writer #(
    .Data_Depth (8), .Channels (3), .Amba_Addr_Depth (AW), .Block_Depth (7), .Max_Img_Size (720)
  ) dut (
    .clk (clk), .rst (rst), .cfg_start (cfg_start), .cfg_Np (cfg_Np), .cfg_M (cfg_M),
    .cfg_bypass (cfg_bypass), .in_valid (in_valid), .in_data (in_data), .in_ready (in_ready),
    .wr_en (wr_en), .wr_addr (wr_addr), .wr_data (wr_data), .wr_ready (wr_ready),
    .busy (busy), .frame_done (frame_done), .cfg_err (cfg_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } exp_t;

  exp_t sb[$];
  int   exp_addr[$];
  int   n_checks = 0;
  int   n_pass = 0;
  int   n_done = 0;
  bit   saw_ready = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
  endtask

  function automatic logic [DW-1:0] data_of(input int k);
    logic [31:0] v;
    v = (32'(k) * 32'h0001_0307) ^ 32'h00C3_5A96;
    return v[DW-1:0];
  endfunction

  // Monitor: every accepted write is checked against the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rst && wr_en && wr_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_write", 32'(wr_addr), 32'hFFFF_FFFF);
      end else begin
        e = sb.pop_front();
        chk("wr_addr", 32'(wr_addr), 32'(e.addr));
        chk("wr_data", 32'(wr_data), 32'(e.data));
      end
    end
    if (frame_done) n_done++;
    if (in_ready) saw_ready = 1'b1;
  end

  task automatic start(input int np, input int m, input bit byp);
    cfg_Np     = 10'(np);
    cfg_M      = 7'(m);
    cfg_bypass = byp;
    cfg_start  = 1'b1;
    @(posedge clk); #1;
    cfg_start  = 1'b0;
  endtask

  task automatic send_beat(input int k, input logic [AW-1:0] a);
    bit ok;
    ok = 1'b0;
    sb.push_back('{a, data_of(k)});
    in_valid = 1'b1;
    in_data  = data_of(k);
    for (int c = 0; c < 200 && !ok; c++) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (!ok) begin
      chk("accept_timeout", 32'd0, 32'd1);
    end else begin
      chk("latency_wr_en", 32'(wr_en), 32'd1);
      chk("latency_wr_addr", 32'(wr_addr), 32'(a));
    end
  endtask

  task automatic run_frame(input int np, input int m, input bit byp, input int n,
                           input int cfg_at, input int stall_at);
    start(np, m, byp);
    for (int k = 0; k < n; k++) begin
      if (k == cfg_at) begin
        cfg_Np = 10'd4; cfg_M = 7'd2; cfg_bypass = 1'b1; cfg_start = 1'b1;
      end
      send_beat(k, AW'(exp_addr[k]));
      cfg_start = 1'b0;
      if (k == stall_at) begin
        wr_ready = 1'b0;
        in_valid = 1'b1;
        in_data  = data_of(k + 1);
        for (int s = 0; s < 5; s++) begin
          @(negedge clk);
          chk("stall_wr_en", 32'(wr_en), 32'd1);
          chk("stall_wr_addr", 32'(wr_addr), 32'(exp_addr[k]));
          chk("stall_wr_data", 32'(wr_data), 32'(data_of(k)));
          chk("stall_in_ready", 32'(in_ready), 32'd0);
          @(posedge clk); #1;
        end
        wr_ready = 1'b1;
      end
    end
  endtask

  task automatic wait_done(input int done_req);
    bit got;
    got = 1'b0;
    for (int c = 0; c < 200 && !got; c++) begin
      @(negedge clk);
      got = frame_done;
    end
    chk("frame_done_seen", 32'(got), 32'd1);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    @(posedge clk); #1;
    chk("idle_after_done", 32'(busy), 32'd0);
    chk("frame_done_count", 32'(n_done), 32'(done_req));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1);
  end

  initial begin
    #2;
    chk("rst_wr_en", 32'(wr_en), 32'd0);
    chk("rst_wr_addr", 32'(wr_addr), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_cfg_err", 32'(cfg_err), 32'd0);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;

    // Np=6, M=3 with an ignored cfg_start pulse at beat 11.
    exp_addr = '{0,1,2,6,7,8,12,13,14, 3,4,5,9,10,11,15,16,17,
                 18,19,20,24,25,26,30,31,32, 21,22,23,27,28,29,33,34,35};
    run_frame(6, 3, 1'b0, 36, 10, -1);
    wait_done(1);

    // Same frame with the write port stalled for 5 cycles on beat 4.
    run_frame(6, 3, 1'b0, 36, -1, 3);
    wait_done(2);

    // M=4 does not tile Np=6.
    saw_ready = 1'b0;
    in_valid  = 1'b1;
    start(6, 4, 1'b0);
    for (int c = 0; c < 50 && !cfg_err; c++) @(negedge clk);
    chk("err_cfg_err", 32'(cfg_err), 32'd1);
    chk("err_busy", 32'(busy), 32'd0);
    repeat (3) @(negedge clk);
    chk("err_in_ready_never", 32'(saw_ready), 32'd0);
    @(posedge clk); #1;
    in_valid = 1'b0;

    // Bypass, Np=4, 24-bit beats.
    exp_addr.delete();
    for (int i = 0; i < 16; i++) exp_addr.push_back(i);
    run_frame(4, 2, 1'b1, 16, -1, -1);
    chk("bypass_cfg_err_cleared", 32'(cfg_err), 32'd0);
    wait_done(3);

    // Np=720, M=72: first block rows are raster rows of 72 pixels.
    exp_addr.delete();
    for (int k = 0; k < 1000; k++) exp_addr.push_back((k / 72) * 720 + (k % 72));
    run_frame(720, 72, 1'b0, 1000, -1, -1);
    rst = 1'b0;
    #1;
    chk("arst_wr_en", 32'(wr_en), 32'd0);
    chk("arst_wr_addr", 32'(wr_addr), 32'd0);
    chk("arst_wr_data", 32'(wr_data), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_in_ready", 32'(in_ready), 32'd0);
    chk("arst_frame_done", 32'(frame_done), 32'd0);
    chk("arst_cfg_err", 32'(cfg_err), 32'd0);
    chk("arst_pending_writes", 32'(sb.size()), 32'd1);
    sb.delete();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b1;
    repeat (5) @(negedge clk);
    chk("post_rst_no_write", 32'(wr_en), 32'd0);
    chk("post_rst_idle", 32'(busy), 32'd0);
    @(posedge clk); #1;
    in_valid = 1'b0;

    exp_addr = '{0,1,6,7, 2,3,8,9, 4,5,10,11, 12,13,18,19, 14,15,20,21, 16,17,22,23,
                 24,25,30,31, 26,27,32,33, 28,29,34,35};
    run_frame(6, 2, 1'b0, 36, -1, -1);
    wait_done(4);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
